reg_scoreboard: RTL and testbench
=================================

Name: reg_scoreboard

Overview:
- Hazard controller that sequences the decode stage's use of the register file.
- Tracks outstanding vector-register writes per register and grants decode issue only when no hazard exists.
  - All source operands must be valid.
  - The destination must have pending-write headroom.
  - Execute must not be busy.
- Provides a drain FSM so halt/context-switch logic can wait for every in-flight write to retire.

Parameters:
- NUM_REGS, 16, number of architectural registers tracked.
- REG_ID_WIDTH, 4, width of a register ID; must equal clog2(NUM_REGS).
- PEND_WIDTH, 2, width of each per-register pending-write counter; max outstanding writes per register = 2^PEND_WIDTH-1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- issue_valid  in  1  decode has an instruction ready to send to execute.
- issue_src_mask  in  NUM_REGS  bit i set = instruction reads register i.
- issue_has_dst  in  1  instruction writes a register.
- issue_dst  in  REG_ID_WIDTH  destination register ID.
- issue_ready  out  1  grant; a fire occurs when issue_valid && issue_ready.
- exec_busy  in  1  execute stage is busy.
- wb_valid  in  1  execute retired one register write this cycle.
- wb_reg  in  REG_ID_WIDTH  register written back.
- flush  in  1  discard all pending state.
- drain_req  in  1  request to quiesce.
- drain_done  out  1  one-cycle pulse when quiesced.
- reg_valid  out  NUM_REGS  bit i = 1 when pend[i] == 0.
- stall_count  out  32  cycles on which issue_valid was high but issue_ready was low.
- error  out  1  sticky writeback-underflow flag.

Behaviour:
- One clock and one reset: clk, with synchronous active-high reset.
- Reset values:
  - All pend[i] = 0, so reg_valid is all ones.
  - issue_ready is combinational and is 0 while reset is high.
  - stall_count = 0, error = 0, drain_done = 0, FSM in IDLE.
- issue_ready (combinational):
  - Requires: !reset && !flush && state == IDLE && !exec_busy.
  - Requires: (issue_src_mask & ~reg_valid) == 0.
  - Requires: (!issue_has_dst || pend[issue_dst] != max).
  - Does not depend on issue_valid.
- No same-cycle bypass:
  - reg_valid and the hazard check use registered pend values only.
  - A writeback on cycle N unblocks a dependent issue no earlier than cycle N+1.
- Counter update per edge (when not in reset or flush):
  - pend[dst] += fire && has_dst.
  - pend[wb_reg] -= wb_valid.
  - A simultaneous fire and wb to the same register leaves the count unchanged.
- Latency: on a fire with a destination at edge N, reg_valid[dst] goes low from cycle N+1.
- WAW: multiple outstanding writes to the same register are allowed up to max. In-order retirement is guaranteed by execute.
- Underflow:
  - Condition: wb_valid to a register with pend == 0 and no same-cycle fire to that register.
  - Response: the count stays 0 and error sets. error clears only on reset.
- flush has priority over issue and wb:
  - All pend cleared next edge.
  - FSM returns to IDLE; no drain_done pulse.
  - stall_count is not cleared.
- stall_count:
  - Increments when issue_valid && !issue_ready, including cycles in DRAIN.
  - Saturates at 0xFFFFFFFF.
- Drain FSM:
  - IDLE: drain_req -> DRAIN.
  - DRAIN: issue_ready = 0. When all pend are 0 (registered) -> DONE. Writebacks continue to be accepted.
  - DONE: drain_done = 1 for exactly this cycle. Next state is IDLE if drain_req is low, otherwise HOLD.
  - HOLD: issue_ready = 0 and drain_done = 0. Leave to IDLE when drain_req falls.
  - drain_req asserted with all counters already 0: drain_done pulses 2 cycles after the edge that samples drain_req (IDLE -> DRAIN -> DONE).
- Reset mid-operation, in any state, returns everything to reset values on the next edge.

Test Plan:
- Fire dst=3 with no sources at edge 0; then issue src_mask=0x0008 -> reg_valid[3]=0 from cycle 1; issue_ready=0 until wb_reg=3 at cycle 5; issue_ready=1 at cycle 6, not at cycle 5.
- Issue dst=2 three times with no wb (PEND_WIDTH=2) -> pend[2]=3; fourth issue to dst=2 gets issue_ready=0; a same-cycle fire dst=2 and wb_reg=2 at pend=2 leaves pend=2.
- exec_busy=1 for 4 cycles with issue_valid=1 and no hazards -> issue_ready=0; stall_count increments by exactly 4.
- wb_valid to reg 7 with pend[7]=0 -> error=1 and stays 1; pend[7]=0; reset clears error.
- Pending dst=1 and dst=5, then drain_req=1 -> issue_ready=0; wb 1 at cycle 3 and wb 5 at cycle 6 -> drain_done pulses once when the FSM reaches DONE; with drain_req held the FSM enters HOLD; drain_req low -> IDLE, issue_ready=1.
- flush during DRAIN with pend[4]=2 -> next cycle reg_valid=0xFFFF, FSM in IDLE, no drain_done pulse.

Source files
------------

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : reg_scoreboard
// Brief    : Per-register pending-write scoreboard gating decode issue, with
//            a drain sequencer for halt / context-switch quiescing.
// Revision : 1.0 - initial release
// ============================================================================
module reg_scoreboard #(
    parameter int NUM_REGS     = 16,
    parameter int REG_ID_WIDTH = 4,
    parameter int PEND_WIDTH   = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    issue_valid,
    input  logic [NUM_REGS-1:0]     issue_src_mask,
    input  logic                    issue_has_dst,
    input  logic [REG_ID_WIDTH-1:0] issue_dst,
    output logic                    issue_ready,
    input  logic                    exec_busy,
    input  logic                    wb_valid,
    input  logic [REG_ID_WIDTH-1:0] wb_reg,
    input  logic                    flush,
    input  logic                    drain_req,
    output logic                    drain_done,
    output logic [NUM_REGS-1:0]     reg_valid,
    output logic [31:0]             stall_count,
    output logic                    error
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_DONE  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;

    state_t                state_q, state_d;
    logic [PEND_WIDTH-1:0] pend_q [NUM_REGS];
    logic [PEND_WIDTH-1:0] pend_d [NUM_REGS];
    logic                  error_q;
    logic                  underflow_d;
    logic [31:0]           stall_q;
    logic                  w_src_ok;
    logic                  w_dst_ok;
    logic                  w_fire;
    logic                  w_all_idle;

    generate
        for (genvar g = 0; g < NUM_REGS; g++) begin : g_valid
            assign reg_valid[g] = (pend_q[g] == '0);
        end
    endgenerate

    // Hazard check sees registered counters only; no writeback bypass.
    assign w_all_idle  = &reg_valid;
    assign w_src_ok    = ((issue_src_mask & ~reg_valid) == '0);
    assign w_dst_ok    = !issue_has_dst || (pend_q[issue_dst] != PEND_MAX);
    assign issue_ready = !reset && !flush && (state_q == S_IDLE) && !exec_busy
                         && w_src_ok && w_dst_ok;
    assign w_fire      = issue_valid && issue_ready;
    assign drain_done  = (state_q == S_DONE);
    assign stall_count = stall_q;
    assign error       = error_q;

    always_comb begin
        underflow_d = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            pend_d[i] = pend_q[i];
            if (w_fire && issue_has_dst && (issue_dst == REG_ID_WIDTH'(i))) begin
                if (!(wb_valid && (wb_reg == REG_ID_WIDTH'(i)))) begin
                    pend_d[i] = pend_q[i] + PEND_WIDTH'(1);
                end
            end else if (wb_valid && (wb_reg == REG_ID_WIDTH'(i))) begin
                if (pend_q[i] == '0) begin
                    underflow_d = 1'b1;
                end else begin
                    pend_d[i] = pend_q[i] - PEND_WIDTH'(1);
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (drain_req) state_d = S_DRAIN;
            S_DRAIN: if (w_all_idle) state_d = S_DONE;
            S_DONE:  state_d = drain_req ? S_HOLD : S_IDLE;
            S_HOLD:  if (!drain_req) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            error_q <= 1'b0;
            stall_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) pend_q[i] <= '0;
        end else begin
            if (issue_valid && !issue_ready && (stall_q != 32'hFFFF_FFFF)) begin
                stall_q <= stall_q + 32'd1;
            end
            // Flush discards pending state and any writeback seen this cycle.
            if (flush) begin
                state_q <= S_IDLE;
                for (int i = 0; i < NUM_REGS; i++) pend_q[i] <= '0;
            end else begin
                state_q <= state_d;
                error_q <= error_q | underflow_d;
                for (int i = 0; i < NUM_REGS; i++) pend_q[i] <= pend_d[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// Testbench for reg_scoreboard: directed table, corner-case sequences and
// randomized traffic checked against an arithmetic reference model.
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [15:0] issue_src_mask;
    logic        issue_has_dst;
    logic [3:0]  issue_dst;
    logic        issue_ready;
    logic        exec_busy;
    logic        wb_valid;
    logic [3:0]  wb_reg;
    logic        flush;
    logic        drain_req;
    logic        drain_done;
    logic [15:0] reg_valid;
    logic [31:0] stall_count;
    logic        error;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg_scoreboard #(.NUM_REGS(16), .REG_ID_WIDTH(4), .PEND_WIDTH(2)) dut (
        .clk(clk), .reset(reset), .issue_valid(issue_valid),
        .issue_src_mask(issue_src_mask), .issue_has_dst(issue_has_dst),
        .issue_dst(issue_dst), .issue_ready(issue_ready), .exec_busy(exec_busy),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .flush(flush), .drain_req(drain_req),
        .drain_done(drain_done), .reg_valid(reg_valid), .stall_count(stall_count),
        .error(error)
    );

    // Reference model: plain integer counters and a drain phase number
    // (0 idle, 1 waiting for writes, 2 done pulse, 3 held after done).
    int          m_pend [16];
    bit          m_err;
    logic [31:0] m_stall;
    int          m_phase;
    localparam int MAXP = 3;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_pend[r]) m_pend[r] = 0;
        m_err = 0; m_stall = 0; m_phase = 0;
    endtask

    function automatic bit m_ready();
        if (reset || flush || m_phase != 0 || exec_busy) return 0;
        for (int r = 0; r < 16; r++)
            if (issue_src_mask[r] && m_pend[r] != 0) return 0;
        if (issue_has_dst && m_pend[issue_dst] == MAXP) return 0;
        return 1;
    endfunction

    task automatic model_edge(input bit rdy);
        bit allz;
        int nv;
        if (reset) begin
            model_reset();
            return;
        end
        if (issue_valid && !rdy && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (flush) begin
            foreach (m_pend[r]) m_pend[r] = 0;
            m_phase = 0;
            return;
        end
        allz = 1;
        foreach (m_pend[r]) if (m_pend[r] != 0) allz = 0;
        for (int r = 0; r < 16; r++) begin
            nv = m_pend[r] + int'(issue_valid && rdy && issue_has_dst && issue_dst == r)
                           - int'(wb_valid && wb_reg == r);
            if (nv < 0) begin
                nv = 0;
                m_err = 1;
            end
            m_pend[r] = nv;
        end
        case (m_phase)
            0: if (drain_req) m_phase = 1;
            1: if (allz) m_phase = 2;
            2: m_phase = drain_req ? 3 : 0;
            default: if (!drain_req) m_phase = 0;
        endcase
    endtask

    // One clock cycle: compare all outputs with the model, then advance both.
    task automatic step();
        bit er;
        logic [15:0] erv;
        #1;
        er = m_ready();
        for (int r = 0; r < 16; r++) erv[r] = (m_pend[r] == 0);
        chk("issue_ready", issue_ready, er);
        chk("reg_valid", reg_valid, erv);
        chk("drain_done", drain_done, m_phase == 2);
        chk("error", error, m_err);
        chk("stall_count", stall_count, m_stall);
        @(posedge clk);
        model_edge(er);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid = 0; issue_src_mask = '0; issue_has_dst = 0; issue_dst = '0;
        exec_busy = 0; wb_valid = 0; wb_reg = '0; flush = 0; drain_req = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        step();
        reset = 0;
    endtask

    task automatic issue(input logic [15:0] src, input logic hd, input logic [3:0] d);
        issue_valid = 1; issue_src_mask = src; issue_has_dst = hd; issue_dst = d;
    endtask

    typedef struct {
        logic        valid;
        logic [15:0] src;
        logic        has_dst;
        logic [3:0]  dst;
        logic        busy;
        logic        wbv;
        logic [3:0]  wbr;
        logic        exp_rdy;
        logic [15:0] exp_rv;
    } vec_t;

    function automatic vec_t mkv(logic v, logic [15:0] s, logic hd, logic [3:0] d, logic b,
                                 logic wv, logic [3:0] wr, logic er, logic [15:0] erv);
        vec_t t;
        t.valid = v; t.src = s; t.has_dst = hd; t.dst = d; t.busy = b;
        t.wbv = wv; t.wbr = wr; t.exp_rdy = er; t.exp_rv = erv;
        return t;
    endfunction

    vec_t tbl [19];

    initial begin
        int dcount;
        logic [31:0] s0;

        tbl[0] = mkv(1, 16'h0000, 1, 4'd3, 0, 0, 4'd0, 1, 16'hFFFF);
        for (int k = 1; k <= 4; k++) tbl[k] = mkv(1, 16'h0008, 0, 4'd0, 0, 0, 4'd0, 0, 16'hFFF7);
        tbl[5]  = mkv(1, 16'h0008, 0, 4'd0, 0, 1, 4'd3, 0, 16'hFFF7);
        tbl[6]  = mkv(1, 16'h0008, 0, 4'd0, 0, 0, 4'd0, 1, 16'hFFFF);
        tbl[7]  = mkv(1, 16'h0000, 1, 4'd2, 0, 0, 4'd0, 1, 16'hFFFF);
        tbl[8]  = mkv(1, 16'h0000, 1, 4'd2, 0, 0, 4'd0, 1, 16'hFFFB);
        tbl[9]  = mkv(1, 16'h0000, 1, 4'd2, 0, 0, 4'd0, 1, 16'hFFFB);
        tbl[10] = mkv(1, 16'h0000, 1, 4'd2, 0, 0, 4'd0, 0, 16'hFFFB);
        tbl[11] = mkv(0, 16'h0000, 0, 4'd0, 0, 1, 4'd2, 1, 16'hFFFB);
        tbl[12] = mkv(1, 16'h0000, 1, 4'd2, 0, 1, 4'd2, 1, 16'hFFFB);
        tbl[13] = mkv(1, 16'h0000, 1, 4'd2, 0, 0, 4'd0, 1, 16'hFFFB);
        tbl[14] = mkv(1, 16'h0000, 1, 4'd2, 0, 0, 4'd0, 0, 16'hFFFB);
        for (int k = 15; k <= 18; k++) tbl[k] = mkv(1, 16'h0000, 0, 4'd0, 1, 0, 4'd0, 0, 16'hFFFB);

        // Power-up reset: registered outputs are unknown until the first edge.
        idle_inputs();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("rst_reg_valid", reg_valid, 16'hFFFF);
        chk("rst_issue_ready", issue_ready, 1'b0);
        chk("rst_stall", stall_count, 32'd0);
        chk("rst_error", error, 1'b0);
        chk("rst_drain_done", drain_done, 1'b0);
        reset = 0;

        // Directed table: RAW on r3, WAW headroom on r2, exec_busy stalls.
        s0 = 0;
        for (int k = 0; k < 19; k++) begin
            issue_valid = tbl[k].valid; issue_src_mask = tbl[k].src;
            issue_has_dst = tbl[k].has_dst; issue_dst = tbl[k].dst;
            exec_busy = tbl[k].busy; wb_valid = tbl[k].wbv; wb_reg = tbl[k].wbr;
            #1;
            chk($sformatf("tbl%0d_ready", k), issue_ready, tbl[k].exp_rdy);
            chk($sformatf("tbl%0d_rv", k), reg_valid, tbl[k].exp_rv);
            if (k == 15) s0 = stall_count;
            step();
        end
        chk("stall_before_busy", s0, 32'd7);
        chk("stall_busy_total", stall_count, 32'd11);

        // Underflow on r7 is sticky until reset.
        do_reset();
        idle_inputs(); wb_valid = 1; wb_reg = 4'd7;
        step();
        idle_inputs();
        chk("uf_error", error, 1'b1);
        chk("uf_rv7", reg_valid[7], 1'b1);
        step(); step();
        chk("uf_sticky", error, 1'b1);
        do_reset();
        chk("uf_reset_clear", error, 1'b0);

        // Drain with pending r1 and r5.
        idle_inputs();
        issue(16'h0, 1, 4'd1); step();
        issue(16'h0, 1, 4'd5); step();
        issue(16'h0, 0, 4'd0); drain_req = 1; step();
        dcount = 0;
        for (int k = 0; k < 12; k++) begin
            wb_valid = (k == 1 || k == 4);
            wb_reg = (k == 1) ? 4'd1 : 4'd5;
            #1;
            chk("drain_ready_low", issue_ready, 1'b0);
            step();
            dcount += int'(drain_done);
        end
        wb_valid = 0;
        chk("drain_pulse_count", dcount, 1);
        chk("hold_done_low", drain_done, 1'b0);
        chk("hold_ready_low", issue_ready, 1'b0);
        drain_req = 0;
        step();
        chk("drain_exit_ready", issue_ready, 1'b1);

        // Drain with nothing pending: DONE two edges after drain_req is sampled.
        idle_inputs(); drain_req = 1;
        step();
        chk("quick_drain_not_yet", drain_done, 1'b0);
        step();
        chk("quick_drain_done", drain_done, 1'b1);
        drain_req = 0;
        step();
        chk("quick_drain_pulse_end", drain_done, 1'b0);

        // Flush in DRAIN with pend[4]=2.
        do_reset();
        issue(16'h0, 1, 4'd4); step(); step();
        idle_inputs(); drain_req = 1; step(); step();
        flush = 1; step();
        flush = 0; drain_req = 0;
        chk("flush_rv", reg_valid, 16'hFFFF);
        chk("flush_done", drain_done, 1'b0);
        issue(16'h0010, 0, 4'd0);
        #1;
        chk("flush_ready", issue_ready, 1'b1);
        step();
        chk("flush_no_pulse", drain_done, 1'b0);

        // Randomized traffic against the model.
        for (int n = 0; n < 800; n++) begin
            int cand;
            reset = ($urandom_range(0, 99) == 0);
            flush = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 19) == 0) drain_req = ~drain_req;
            issue_valid = ($urandom_range(0, 9) < 7);
            issue_src_mask = 16'($urandom) & 16'($urandom) & 16'($urandom);
            issue_has_dst = ($urandom_range(0, 9) < 6);
            issue_dst = 4'($urandom);
            exec_busy = ($urandom_range(0, 9) == 0);
            wb_valid = ($urandom_range(0, 1) == 1);
            cand = $urandom_range(0, 15);
            for (int r = 0; r < 16; r++)
                if (m_pend[(cand + r) % 16] != 0 && $urandom_range(0, 15) != 0) begin
                    cand = (cand + r) % 16;
                    break;
                end
            wb_reg = 4'(cand);
            step();
        end
        reset = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
